mad_unit: RTL and testbench

Multiply/divide unit for the E stage of the pipelined MIPS core. It consumes the MAD control fields that the ID/EX pipeline register delivers (start, operation select, HI/LO write enables) together with the forwarded rs/rt operands. It runs a fixed-latency multicycle operation, holds the HI/LO architectural registers, and exports `busy` so hazard control can stall dependent MAD instructions in D.

---
 rtl/mad_unit_pkg.sv | 23 ++
 rtl/mad_calc.sv | 60 ++++++
 rtl/mad_unit.sv | 99 +++++++++
 tb/tb_mad_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mad_unit_pkg.sv
// rtl/mad_unit_pkg.sv - shared encodings and defaults for the multiply/divide unit
package mad_unit_pkg;

  // Operation select encoding; bit 0 set means the unsigned variant
  typedef enum logic [2:0] {
    MAD_MULT  = 3'd0,
    MAD_MULTU = 3'd1,
    MAD_DIV   = 3'd2,
    MAD_DIVU  = 3'd3,
    MAD_MADD  = 3'd4,
    MAD_MADDU = 3'd5,
    MAD_MSUB  = 3'd6,
    MAD_MSUBU = 3'd7
  } mad_sel_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  function automatic logic is_div_op(input logic [2:0] sel);
    return (sel == MAD_DIV) || (sel == MAD_DIVU);
  endfunction

endpackage

// File: rtl/mad_calc.sv
// rtl/mad_calc.sv - combinational multiply/accumulate/divide result generator
module mad_calc
  import mad_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_zero
);

  logic        sgn;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed ops work on magnitudes so the most-negative / -1 case falls out naturally
  always_comb begin
    sgn      = ~sel[0];
    ext_a    = {{32{a[31] & sgn}}, a};
    ext_b    = {{32{b[31] & sgn}}, b};
    // Low 64 bits of the extended product are correct for both signednesses
    prod     = ext_a * ext_b;
    a_neg    = sgn & a[31];
    b_neg    = sgn & b[31];
    mag_a    = a_neg ? (32'd0 - a) : a;
    mag_b    = b_neg ? (32'd0 - b) : b;
    // A zero divisor is replaced so the divider never sees 0; the result is discarded anyway
    if (b == 32'd0) begin
      mag_b = 32'd1;
    end
    quo_u    = mag_a / mag_b;
    rem_u    = mag_a % mag_b;
    quo      = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
    rem      = a_neg ? (32'd0 - rem_u) : rem_u;
    res      = prod;
    div_zero = 1'b0;
    case (mad_sel_e'(sel))
      MAD_MULT, MAD_MULTU: res = prod;
      MAD_DIV, MAD_DIVU: begin
        res      = {rem, quo};
        div_zero = (b == 32'd0);
      end
      MAD_MADD, MAD_MADDU: res = {hi, lo} + prod;
      MAD_MSUB, MAD_MSUBU: res = {hi, lo} - prod;
      default: res = prod;
    endcase
  end

endmodule

// File: rtl/mad_unit.sv
// rtl/mad_unit.sv - fixed-latency multiply/divide unit holding HI/LO
module mad_unit
  import mad_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MAD_sel,
  input  logic        HI_En,
  input  logic        LO_En,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_zero_q, pend_zero_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      calc_res;
  logic             calc_div_zero;

  mad_calc u_calc (
    .a        (A),
    .b        (B),
    .sel      (MAD_sel),
    .hi       (hi_q),
    .lo       (lo_q),
    .res      (calc_res),
    .div_zero (calc_div_zero)
  );

  // Priority: busy countdown, then a new start, then mthi/mtlo
  always_comb begin
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_zero_d = pend_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        // Divide by zero keeps the architectural HI/LO untouched
        if (!pend_zero_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end
    end else if (start) begin
      pend_d      = calc_res;
      pend_zero_d = calc_div_zero;
      cnt_d       = is_div_op(MAD_sel) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_d      = 1'b1;
    end else begin
      if (HI_En) begin
        hi_d = A;
      end
      if (LO_En) begin
        lo_d = A;
      end
    end
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_zero_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_zero_q <= pend_zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mad_unit.sv
// tb/tb_mad_unit.sv - self-checking bench for mad_unit
module tb_mad_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MAD_sel;
  logic        HI_En;
  logic        LO_En;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  mad_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MAD_sel (MAD_sel),
    .HI_En   (HI_En),
    .LO_En   (LO_En),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO)
  );

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: result of one operation from the arithmetic definitions
  function automatic logic [64:0] model_op(input logic [2:0] sel, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    logic [63:0] acc;
    int          sa;
    int          sb;
    int          q;
    int          r;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = {32'd0, a} * {32'd0, b};
    acc = {hi, lo};
    sa  = a;
    sb  = b;
    case (sel)
      3'd0: return {1'b0, 64'(sp)};
      3'd1: return {1'b0, up};
      3'd2: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
      3'd4: return {1'b0, acc + 64'(sp)};
      3'd5: return {1'b0, acc + up};
      3'd6: return {1'b0, acc - 64'(sp)};
      default: return {1'b0, acc - up};
    endcase
  endfunction

  // Model state: completion is scheduled at an absolute edge number
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  bit          m_busy, m_dz;
  int          edge_no, done_at;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_dz = 0; m_pend = 0; edge_no = 0; done_at = 0;
    end else begin
      edge_no++;
      if (m_busy) begin
        if (edge_no == done_at) begin
          m_busy = 0;
          if (!m_dz) {m_hi, m_lo} = m_pend;
        end
      end else if (start) begin
        {m_dz, m_pend} = model_op(MAD_sel, A, B, m_hi, m_lo);
        m_busy  = 1;
        done_at = edge_no + ((MAD_sel == 3'd2 || MAD_sel == 3'd3) ? 10 : 5);
      end else begin
        if (HI_En) m_hi = A;
        if (LO_En) m_lo = A;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (run_cmp && reset === 1'b1) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_HI", HI, m_hi);
      chk("cyc_LO", LO, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string name, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input int exp_n);
    int n;
    start = 1; MAD_sel = sel; A = a; B = b;
    step();
    start = 0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] v);
    HI_En = to_hi; LO_En = !to_hi; A = v;
    step();
    HI_En = 0; LO_En = 0;
  endtask

  initial begin
    int n;
    reset = 0; start = 0; MAD_sel = 0; HI_En = 0; LO_En = 0; A = 0; B = 0;
    repeat (2) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    reset = 1;
    run_cmp = 1;
    step();

    do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);

    do_op("divu", 3'd3, 32'd7, 32'd2, 10);
    chk("divu_LO", LO, 32'd3);
    chk("divu_HI", HI, 32'd1);

    do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);

    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("div_ovf_LO", LO, 32'h8000_0000);
    chk("div_ovf_HI", HI, 32'd0);

    mt(1, 32'h11);
    mt(0, 32'h22);
    do_op("div0", 3'd2, 32'd5, 32'd0, 10);
    chk("div0_HI", HI, 32'h11);
    chk("div0_LO", LO, 32'h22);

    mt(1, 32'd0);
    mt(0, 32'hFFFF_FFFF);
    do_op("maddu", 3'd5, 32'd1, 32'd1, 5);
    chk("maddu_HI", HI, 32'd1);
    chk("maddu_LO", LO, 32'd0);

    mt(1, 32'd0);
    mt(0, 32'd0);
    do_op("msub", 3'd6, 32'd1, 32'd1, 5);
    chk("msub_HI", HI, 32'hFFFF_FFFF);
    chk("msub_LO", LO, 32'hFFFF_FFFF);

    // Pulses during busy must be ignored and must not extend the operation
    start = 1; MAD_sel = 3'd1; A = 32'd3; B = 32'd4;
    step();
    start = 1; MAD_sel = 3'd2; A = 32'd9; B = 32'd0; HI_En = 1; LO_En = 1;
    step();
    start = 0; HI_En = 0; LO_En = 0;
    n = 1;
    while (busy && n < 200) begin
      n++;
      step();
    end
    chk("ign_busy_cycles", 32'(n), 32'd5);
    chk("ign_HI", HI, 32'd0);
    chk("ign_LO", LO, 32'd12);
    mt(1, 32'h0000_ABCD);
    chk("mthi_after_HI", HI, 32'h0000_ABCD);
    chk("mthi_after_LO", LO, 32'd12);

    // Asynchronous reset in the middle of a divide
    start = 1; MAD_sel = 3'd2; A = 32'd100; B = 32'd7;
    step();
    start = 0;
    step();
    step();
    #2 reset = 0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_HI", HI, 32'd0);
    chk("arst_LO", LO, 32'd0);
    step();
    step();
    reset = 1;
    step();
    do_op("mult_after_rst", 3'd0, 32'd6, 32'd7, 5);
    chk("mult_after_rst_LO", LO, 32'd42);
    chk("mult_after_rst_HI", HI, 32'd0);
    do_op("madd", 3'd4, 32'hFFFF_FFFF, 32'd2, 5);
    chk("madd_LO", LO, 32'd40);
    chk("madd_HI", HI, 32'd0);

    repeat (3) step();
    run_cmp = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
